// File: rtl/beat_timer.sv
// beat_timer: one-hot W1/W2/W3 machine-cycle sequencer with run/halt, single-step and instruction counter.
module beat_timer #(
  parameter int CNT_W = 16
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             DP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  output logic             W1,
  output logic             W2,
  output logic             W3,
  output logic             RUN,
  output logic [CNT_W-1:0] ICNT
);
  typedef enum logic {HALTED, RUNNING} state_e;
  state_e             state_q, state_d;
  logic [2:0]         beat_q, beat_d, nxt;
  logic [1:0]         pnd_q, pnd_d;
  logic               qd_prev_q, qd_rise, fin;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  always_ff @(posedge T3) begin
    if (CLR) begin
      state_q   <= HALTED;
      beat_q    <= 3'b000;
      pnd_q     <= 2'd0;
      qd_prev_q <= 1'b0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pnd_q     <= pnd_d;
      qd_prev_q <= QD;
      icnt_q    <= icnt_d;
    end
  end
  // PND holds the beat index (0=W1, 1=W2, 2=W3) to issue when the start button resumes.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pnd_d   = pnd_q;
    qd_rise = QD & ~qd_prev_q;
    fin     = (state_q == RUNNING) &
              ((beat_q[0] & SHORT) | (beat_q[1] & ~SHORT & ~LONG) | beat_q[2]);
    nxt     = fin ? 3'b001 : {beat_q[1:0], 1'b0};
    icnt_d  = icnt_q + {{(CNT_W-1){1'b0}}, fin};
    if (state_q == RUNNING) begin
      if (STOP | DP) begin
        state_d = HALTED;
        beat_d  = 3'b000;
        pnd_d   = nxt[2] ? 2'd2 : nxt[1] ? 2'd1 : 2'd0;
      end else begin
        beat_d  = nxt;
      end
    end else if (qd_rise) begin
      state_d = RUNNING;
      beat_d  = (pnd_q == 2'd2) ? 3'b100 : (pnd_q == 2'd1) ? 3'b010 : 3'b001;
    end
  end
  assign W1   = beat_q[0];
  assign W2   = beat_q[1];
  assign W3   = beat_q[2];
  assign RUN  = (state_q == RUNNING);
  assign ICNT = icnt_q;
endmodule

// File: tb/tb_beat_timer.sv
// tb_beat_timer: directed self-checking bench for beat_timer.
module tb_beat_timer;
  logic        T3 = 1'b0, CLR = 1'b1, QD = 1'b0, DP = 1'b0, SHORT = 1'b0, LONG = 1'b0, STOP = 1'b0;
  logic        W1, W2, W3, RUN;
  logic [15:0] ICNT;
  int          n_cmp = 0, n_bad = 0;

  beat_timer #(.CNT_W(16)) dut (
    .T3(T3), .CLR(CLR), .QD(QD), .DP(DP), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W1(W1), .W2(W2), .W3(W3), .RUN(RUN), .ICNT(ICNT)
  );

  always #5 T3 = ~T3;

  task automatic tick();
    @(posedge T3);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1; QD = 1'b0; DP = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000 || ICNT !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got W=%b RUN=%b ICNT=%0d want W=000 RUN=0 ICNT=0", {W3, W2, W1}, RUN, ICNT);
    end
    CLR = 1'b0;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000) begin
      n_bad++;
      $display("FAIL post_reset_idle: got W=%b RUN=%b want W=000 RUN=0", {W3, W2, W1}, RUN);
    end
  endtask

  task automatic test_default();
    logic [2:0]  exp_w [5] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    logic [15:0] exp_c [5] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    do_reset();
    QD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      QD = 1'b0;
      n_cmp++;
      if ({W3, W2, W1} !== exp_w[i] || RUN !== 1'b1 || ICNT !== exp_c[i]) begin
        n_bad++;
        $display("FAIL default_seq[%0d]: got W=%b RUN=%b ICNT=%0d want W=%b RUN=1 ICNT=%0d",
                 i, {W3, W2, W1}, RUN, ICNT, exp_w[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_short_long();
    logic [2:0]  exp_w [5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [15:0] exp_c [5] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    logic        sh    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        lg    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    QD = 1'b1;
    tick();
    QD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({W3, W2, W1} !== exp_w[i] || ICNT !== exp_c[i]) begin
        n_bad++;
        $display("FAIL short_long[%0d]: got W=%b ICNT=%0d want W=%b ICNT=%0d",
                 i, {W3, W2, W1}, ICNT, exp_w[i], exp_c[i]);
      end
      SHORT = sh[i];
      LONG  = lg[i];
      tick();
    end
    SHORT = 1'b0;
    LONG  = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    QD = 1'b1;
    tick();
    QD = 1'b0;
    tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000 || ICNT !== 16'd1) begin
      n_bad++;
      $display("FAIL stop_w2: got W=%b RUN=%b ICNT=%0d want W=000 RUN=0 ICNT=1", {W3, W2, W1}, RUN, ICNT);
    end
    SHORT = 1'b1; LONG = 1'b1; DP = 1'b1;
    tick();
    SHORT = 1'b0; LONG = 1'b0; DP = 1'b0;
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000 || ICNT !== 16'd1) begin
      n_bad++;
      $display("FAIL halted_hold: got W=%b RUN=%b ICNT=%0d want W=000 RUN=0 ICNT=1", {W3, W2, W1}, RUN, ICNT);
    end
    QD = 1'b1;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0011) begin
      n_bad++;
      $display("FAIL stop_resume: got W=%b RUN=%b want W=001 RUN=1", {W3, W2, W1}, RUN);
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000) begin
      n_bad++;
      $display("FAIL qd_level_no_rise: got W=%b RUN=%b want W=000 RUN=0", {W3, W2, W1}, RUN);
    end
    QD = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    QD = 1'b0;
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0101 || ICNT !== 16'd1) begin
      n_bad++;
      $display("FAIL resume_pnd_w2: got W=%b RUN=%b ICNT=%0d want W=010 RUN=1 ICNT=1", {W3, W2, W1}, RUN, ICNT);
    end
  endtask

  task automatic test_single_step();
    logic [2:0]  exp_w [3] = '{3'b001, 3'b010, 3'b100};
    logic [15:0] exp_c [3] = '{16'd0, 16'd0, 16'd1};
    do_reset();
    DP = 1'b1;
    LONG = 1'b1;
    for (int i = 0; i < 3; i++) begin
      QD = 1'b1;
      tick();
      QD = 1'b0;
      n_cmp++;
      if ({W3, W2, W1} !== exp_w[i] || RUN !== 1'b1) begin
        n_bad++;
        $display("FAIL step_beat[%0d]: got W=%b RUN=%b want W=%b RUN=1", i, {W3, W2, W1}, RUN, exp_w[i]);
      end
      tick();
      n_cmp++;
      if ({W3, W2, W1, RUN} !== 4'b0000 || ICNT !== exp_c[i]) begin
        n_bad++;
        $display("FAIL step_halt[%0d]: got W=%b RUN=%b ICNT=%0d want W=000 RUN=0 ICNT=%0d",
                 i, {W3, W2, W1}, RUN, ICNT, exp_c[i]);
      end
    end
    DP = 1'b0;
    LONG = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    SHORT = 1'b1;
    QD = 1'b1;
    tick();
    QD = 1'b0;
    repeat (65535) tick();
    n_cmp++;
    if (ICNT !== 16'hFFFF || {W3, W2, W1} !== 3'b001) begin
      n_bad++;
      $display("FAIL icnt_max: got ICNT=%h W=%b want ICNT=ffff W=001", ICNT, {W3, W2, W1});
    end
    tick();
    n_cmp++;
    if (ICNT !== 16'h0000 || RUN !== 1'b1) begin
      n_bad++;
      $display("FAIL icnt_wrap: got ICNT=%h RUN=%b want ICNT=0000 RUN=1", ICNT, RUN);
    end
    SHORT = 1'b0;
  endtask

  task automatic test_clr_mid();
    logic [2:0] exp_w [3] = '{3'b010, 3'b001, 3'b010};
    logic       qd    [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    LONG = 1'b1;
    QD = 1'b1;
    tick();
    QD = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({W3, W2, W1} !== 3'b100) begin
      n_bad++;
      $display("FAIL clr_setup_w3: got W=%b want W=100", {W3, W2, W1});
    end
    STOP = 1'b1;
    QD = 1'b1;
    CLR = 1'b1;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0000 || ICNT !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_mid: got W=%b RUN=%b ICNT=%0d want W=000 RUN=0 ICNT=0", {W3, W2, W1}, RUN, ICNT);
    end
    CLR = 1'b0; STOP = 1'b0; LONG = 1'b0;
    tick();
    n_cmp++;
    if ({W3, W2, W1, RUN} !== 4'b0011) begin
      n_bad++;
      $display("FAIL qd_held_start: got W=%b RUN=%b want W=001 RUN=1", {W3, W2, W1}, RUN);
    end
    for (int i = 0; i < 3; i++) begin
      QD = qd[i];
      tick();
      n_cmp++;
      if ({W3, W2, W1} !== exp_w[i] || RUN !== 1'b1) begin
        n_bad++;
        $display("FAIL qd_ignored_running[%0d]: got W=%b RUN=%b want W=%b RUN=1", i, {W3, W2, W1}, RUN, exp_w[i]);
      end
    end
    QD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_short_long();
    test_stop();
    test_single_step();
    test_wrap();
    test_clr_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
